// File: rtl/addsub_arbiter_if.sv
`default_nettype none
// ==================================================================
// addsub_arbiter_if : request/result/unit bus of the add/sub arbiter
// Rev 1.0
// ==================================================================
interface addsub_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_sub;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_sub;
    logic        res0_valid;
    logic        res0_ready;
    logic        res1_valid;
    logic        res1_ready;
    logic [31:0] res_data;
    logic        res_cout;
    logic [31:0] au_a;
    logic [31:0] au_b;
    logic        au_sub;
    logic [31:0] au_sum;
    logic        au_cout;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  res0_ready, res1_ready, au_sum, au_cout,
        output req0_ready, req1_ready, res0_valid, res1_valid,
        output res_data, res_cout, au_a, au_b, au_sub
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output res0_ready, res1_ready, au_sum, au_cout,
        input  req0_ready, req1_ready, res0_valid, res1_valid,
        input  res_data, res_cout, au_a, au_b, au_sub
    );
endinterface
`default_nettype wire

// File: rtl/addsub_arbiter.sv
`default_nettype none
// ==================================================================
// addsub_arbiter : round-robin sharing of one 32-bit add/sub unit
// Rev 1.0
// ==================================================================
module addsub_arbiter #(
    parameter int LATENCY = 1
) (
    input wire              clk,
    input wire              clr,
    addsub_arbiter_if.slave bus
);
    localparam logic [3:0] c_COUNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t      state_q;
    logic        owner_q;
    logic        last_grant_q;
    logic [3:0]  count_q;
    logic [31:0] au_a_q;
    logic [31:0] au_b_q;
    logic        au_sub_q;
    logic [31:0] res_data_q;
    logic        res_cout_q;
    logic        res0_valid_q;
    logic        res1_valid_q;

    logic w_idle;
    logic w_grant;
    logic w_ready0;
    logic w_ready1;
    logic w_hs;
    logic w_consume;

    // Readies are masked by clr so nothing looks accepted while reset is held.
    assign w_idle    = (state_q == S_IDLE) && !clr;
    assign w_grant   = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    assign w_ready0  = w_idle && bus.req0_valid && !w_grant;
    assign w_ready1  = w_idle && bus.req1_valid && w_grant;
    assign w_hs      = w_ready0 | w_ready1;
    assign w_consume = owner_q ? bus.res1_ready : bus.res0_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            count_q      <= 4'd0;
            au_a_q       <= 32'd0;
            au_b_q       <= 32'd0;
            au_sub_q     <= 1'b0;
            res_data_q   <= 32'd0;
            res_cout_q   <= 1'b0;
            res0_valid_q <= 1'b0;
            res1_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_hs) begin
                        au_a_q       <= w_grant ? bus.req1_a   : bus.req0_a;
                        au_b_q       <= w_grant ? bus.req1_b   : bus.req0_b;
                        au_sub_q     <= w_grant ? bus.req1_sub : bus.req0_sub;
                        owner_q      <= w_grant;
                        last_grant_q <= w_grant;
                        count_q      <= c_COUNT_LOAD;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (count_q != 4'd0) begin
                        count_q <= count_q - 4'd1;
                    end else begin
                        res_data_q   <= bus.au_sum;
                        res_cout_q   <= bus.au_cout;
                        res0_valid_q <= ~owner_q;
                        res1_valid_q <= owner_q;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_consume) begin
                        res0_valid_q <= 1'b0;
                        res1_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.res0_valid = res0_valid_q;
    assign bus.res1_valid = res1_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_cout   = res_cout_q;
    assign bus.au_a       = au_a_q;
    assign bus.au_b       = au_b_q;
    assign bus.au_sub     = au_sub_q;
endmodule
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// ==================================================================
// tb_addsub_arbiter : directed bench for addsub_arbiter (LATENCY 1 and 4)
// Rev 1.0
// ==================================================================
module tb_addsub_arbiter;
    logic clk = 1'b0;
    logic clr = 1'b1;
    logic junk_b = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    addsub_arbiter_if ifa ();
    addsub_arbiter_if ifb ();

    addsub_arbiter #(.LATENCY(1)) u_dut1 (.clk(clk), .clr(clr), .bus(ifa));
    addsub_arbiter #(.LATENCY(4)) u_dut4 (.clk(clk), .clr(clr), .bus(ifb));

    // Reference add/sub units; unit B can be forced to garbage before capture.
    logic [32:0] w_ua;
    logic [32:0] w_ub;
    always_comb begin
        w_ua = ifa.au_sub ? ({1'b0, ifa.au_a} + {1'b0, ~ifa.au_b} + 33'd1)
                          : ({1'b0, ifa.au_a} + {1'b0, ifa.au_b});
        w_ub = ifb.au_sub ? ({1'b0, ifb.au_a} + {1'b0, ~ifb.au_b} + 33'd1)
                          : ({1'b0, ifb.au_a} + {1'b0, ifb.au_b});
    end
    assign ifa.au_sum  = w_ua[31:0];
    assign ifa.au_cout = w_ua[32];
    assign ifb.au_sum  = junk_b ? 32'hDEAD_BEEF : w_ub[31:0];
    assign ifb.au_cout = junk_b ? ~w_ub[32] : w_ub[32];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic op_a(input logic r, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] exp_d, input logic exp_c,
                        input string tag);
        int n;
        @(negedge clk);
        if (r) begin
            ifa.req1_valid = 1'b1; ifa.req1_a = a; ifa.req1_b = b; ifa.req1_sub = s;
        end else begin
            ifa.req0_valid = 1'b1; ifa.req0_a = a; ifa.req0_b = b; ifa.req0_sub = s;
        end
        #1;
        n = 0;
        while (!(r ? ifa.req1_ready : ifa.req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check({tag, "_hs_wait"}, n, 0);
        check({tag, "_other_ready"}, r ? ifa.req0_ready : ifa.req1_ready, 0);
        @(negedge clk); #1;
        check({tag, "_ready_issue"}, r ? ifa.req1_ready : ifa.req0_ready, 0);
        check({tag, "_valid_issue"}, {ifa.res0_valid, ifa.res1_valid}, 0);
        ifa.req0_valid = 1'b0;
        ifa.req1_valid = 1'b0;
        @(negedge clk); #1;
        check({tag, "_res_valid"}, r ? ifa.res1_valid : ifa.res0_valid, 1);
        check({tag, "_other_valid"}, r ? ifa.res0_valid : ifa.res1_valid, 0);
        check({tag, "_data"}, ifa.res_data, exp_d);
        check({tag, "_cout"}, ifa.res_cout, exp_c);
        if (r) ifa.res1_ready = 1'b1; else ifa.res0_ready = 1'b1;
        @(negedge clk);
        ifa.res0_ready = 1'b0;
        ifa.res1_ready = 1'b0;
        #1;
        check({tag, "_res_drop"}, {ifa.res0_valid, ifa.res1_valid}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g[4];
        int t[4];
        int k;
        ifa.req0_valid = 0; ifa.req0_a = 0; ifa.req0_b = 0; ifa.req0_sub = 0;
        ifa.req1_valid = 0; ifa.req1_a = 0; ifa.req1_b = 0; ifa.req1_sub = 0;
        ifa.res0_ready = 0; ifa.res1_ready = 0;
        ifb.req0_valid = 0; ifb.req0_a = 0; ifb.req0_b = 0; ifb.req0_sub = 0;
        ifb.req1_valid = 0; ifb.req1_a = 0; ifb.req1_b = 0; ifb.req1_sub = 0;
        ifb.res0_ready = 0; ifb.res1_ready = 0;

        // Reset state, with a request waiting to confirm readies are held off.
        @(negedge clk); @(negedge clk);
        ifa.req0_valid = 1'b1;
        #1;
        check("rst_ready0", ifa.req0_ready, 0);
        check("rst_res_valid", {ifa.res0_valid, ifa.res1_valid}, 0);
        check("rst_au_a", ifa.au_a, 0);
        check("rst_au_b_sub", {ifa.au_sub, ifa.au_b}, 0);
        check("rst_res", {ifa.res_cout, ifa.res_data}, 0);
        check("rst4_res_valid", {ifb.res0_valid, ifb.res1_valid}, 0);
        ifa.req0_valid = 1'b0;
        @(negedge clk);
        clr = 1'b0;

        op_a(1'b0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, "add");
        op_a(1'b1, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, "sub_borrow");
        op_a(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, "add_wrap");

        // Tie fairness: both requesters continuously valid, results always taken.
        @(negedge clk);
        ifa.req0_valid = 1; ifa.req0_a = 32'd10; ifa.req0_b = 32'd1; ifa.req0_sub = 0;
        ifa.req1_valid = 1; ifa.req1_a = 32'd20; ifa.req1_b = 32'd2; ifa.req1_sub = 1;
        ifa.res0_ready = 1; ifa.res1_ready = 1;
        #1;
        k = 0;
        for (int i = 0; i < 4; i++) begin g[i] = -1; t[i] = -1; end
        for (int c = 0; c < 40 && k < 4; c++) begin
            check("tie_ready_excl", ifa.req0_ready & ifa.req1_ready, 0);
            check("tie_valid_excl", ifa.res0_valid & ifa.res1_valid, 0);
            if (ifa.res0_valid) check("tie_res0_data", ifa.res_data, 32'd11);
            if (ifa.res1_valid) check("tie_res1_data", ifa.res_data, 32'd18);
            if (ifa.req0_ready || ifa.req1_ready) begin
                g[k] = int'(ifa.req1_ready); t[k] = c; k++;
            end
            @(negedge clk); #1;
        end
        ifa.req0_valid = 0;
        ifa.req1_valid = 0;
        check("tie_ops", k, 4);
        check("tie_g0", g[0], 0);
        check("tie_g1", g[1], 1);
        check("tie_g2", g[2], 0);
        check("tie_g3", g[3], 1);
        for (int i = 1; i < 4; i++) check("tie_interval", t[i] - t[i-1], 3);
        @(negedge clk); #1;
        check("tie_last_valid", ifa.res1_valid, 1);
        check("tie_last_data", ifa.res_data, 32'd18);
        @(negedge clk);
        ifa.res0_ready = 0;
        ifa.res1_ready = 0;

        // Backpressure: requester 0 holds its result, requester 1 waits.
        @(negedge clk);
        ifa.req0_valid = 1; ifa.req0_a = 32'd7; ifa.req0_b = 32'd9; ifa.req0_sub = 0;
        #1;
        check("bp_ready0", ifa.req0_ready, 1);
        @(negedge clk);
        ifa.req0_valid = 0;
        ifa.req1_valid = 1; ifa.req1_a = 32'd1; ifa.req1_b = 32'd1; ifa.req1_sub = 0;
        #1;
        check("bp_ready1_issue", ifa.req1_ready, 0);
        @(negedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", ifa.res0_valid, 1);
            check("bp_hold_data", ifa.res_data, 32'd16);
            check("bp_hold_cout", ifa.res_cout, 0);
            check("bp_ready1_wait", ifa.req1_ready, 0);
            ifa.res1_ready = 1'b1;   // ignored: requester 1 does not own the result
            @(negedge clk); #1;
        end
        ifa.res1_ready = 1'b0;
        ifa.res0_ready = 1'b1;
        #1;
        check("bp_ready1_consume", ifa.req1_ready, 0);
        @(negedge clk);
        ifa.res0_ready = 1'b0;
        #1;
        check("bp_res0_drop", ifa.res0_valid, 0);
        check("bp_ready1_after", ifa.req1_ready, 1);
        @(negedge clk);
        ifa.req1_valid = 0;
        @(negedge clk); #1;
        check("bp_res1_valid", {ifa.res0_valid, ifa.res1_valid}, 2'b01);
        check("bp_res1_data", ifa.res_data, 32'd2);
        ifa.res1_ready = 1'b1;
        @(negedge clk);
        ifa.res1_ready = 1'b0;

        // LATENCY=4: operands held, garbage on au_sum until the final cycle.
        @(negedge clk);
        junk_b = 1'b1;
        ifb.req0_valid = 1; ifb.req0_a = 32'h1234_5678; ifb.req0_b = 32'h1111_1111; ifb.req0_sub = 1;
        #1;
        check("l4_ready0", ifb.req0_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) ifb.req0_valid = 0;
            if (i == 3) junk_b = 1'b0;
            #1;
            check("l4_au_a", ifb.au_a, 32'h1234_5678);
            check("l4_au_b_sub", {ifb.au_sub, ifb.au_b}, {1'b1, 32'h1111_1111});
            check("l4_no_res", ifb.res0_valid, 0);
        end
        @(negedge clk); #1;
        check("l4_res_valid", {ifb.res0_valid, ifb.res1_valid}, 2'b10);
        check("l4_data", ifb.res_data, 32'h0123_4567);
        check("l4_cout", ifb.res_cout, 1);
        ifb.res0_ready = 1'b1;
        @(negedge clk);
        ifb.res0_ready = 1'b0;

        // Reset in the middle of an ISSUE on the LATENCY=4 instance.
        @(negedge clk);
        ifb.req0_valid = 1; ifb.req0_a = 32'd100; ifb.req0_b = 32'd1; ifb.req0_sub = 0;
        #1;
        check("mr_ready0", ifb.req0_ready, 1);
        @(negedge clk);
        ifb.req0_valid = 0;
        #1;
        check("mr_au_a", ifb.au_a, 32'd100);
        #2;
        clr = 1'b1;
        ifb.req0_valid = 1; ifb.req0_a = 32'd40; ifb.req0_b = 32'd2; ifb.req0_sub = 0;
        ifb.req1_valid = 1; ifb.req1_a = 32'd9;  ifb.req1_b = 32'd9; ifb.req1_sub = 0;
        #1;
        check("mr_readies", {ifb.req0_ready, ifb.req1_ready}, 0);
        check("mr_res_valid", {ifb.res0_valid, ifb.res1_valid}, 0);
        check("mr_au_a_clr", ifb.au_a, 0);
        check("mr_au_b_sub", {ifb.au_sub, ifb.au_b}, 0);
        check("mr_res", {ifb.res_cout, ifb.res_data}, 0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("mr_grant0", {ifb.req0_ready, ifb.req1_ready}, 2'b10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin ifb.req0_valid = 0; ifb.req1_valid = 0; end
            #1;
            check("mr_no_stale", {ifb.res0_valid, ifb.res1_valid}, 0);
        end
        @(negedge clk); #1;
        check("mr_res0_valid", {ifb.res0_valid, ifb.res1_valid}, 2'b10);
        check("mr_data", ifb.res_data, 32'd42);
        ifb.res0_ready = 1'b1;
        @(negedge clk);
        ifb.res0_ready = 1'b0;
        #1;
        check("mr_res_drop", ifb.res0_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/addsub_arbiter.md
# addsub_arbiter

Shares the single 32-bit add/subtract unit of the CPU datapath between two requesters (requester 0: ALU ADD/SUB path; requester 1: address/PC arithmetic). It accepts operand requests over a valid/ready handshake, grants the unit round-robin, drives it for a fixed settle time, captures sum and carry into a result register and returns them to the granted requester. One operation is in flight at a time.

## Interface
- LATENCY, 1: cycles the unit operands are held before the result is captured (1..15).
- clk  in  1  system clock, all state on rising edge
- clr  in  1  reset, asynchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- req0_sub / req1_sub  in  1  0 = a+b, 1 = a-b
- res0_valid / res1_valid  out  1  result available to that requester
- res0_ready / res1_ready  in  1  requester consumes result
- res_data  out  32  captured sum/difference (shared by both result ports)
- res_cout  out  1  captured carry-out (for sub: 1 = no borrow)
- au_a, au_b  out  32  operands to add/sub unit (registered)
- au_sub  out  1  selects subtract in unit (registered)
- au_sum  in  32  unit result
- au_cout  in  1  unit carry-out

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: arbitrate combinationally. One valid -> grant it. Both valid -> grant the one not granted last (last_grant pointer, reset value 1, so requester 0 wins the first tie). reqN_ready = 1 only for the granted requester, only in IDLE. On handshake: latch a, b, sub into au_a/au_b/au_sub, record owner, update last_grant, load count = LATENCY-1, go ISSUE. No valid -> stay IDLE, no readies.
- ISSUE: au_* held constant. count > 0 -> decrement. count == 0 -> capture au_sum into res_data and au_cout into res_cout, go RESP.
- RESP: resN_valid = 1 for owner only, res_data/res_cout stable. resN_ready high on owner -> go IDLE next cycle. ready from non-owner ignored. Requests arriving in ISSUE/RESP wait (ready stays 0); requester must hold valid and operands stable until ready.
- Unit function expected by bench model: sub=0 -> {cout,sum} = a+b; sub=1 -> {cout,sum} = a + ~b + 1 (33-bit), wraps modulo 2^32.
- Reset (any state, any time): state IDLE, all readies/res_valids 0, au_a/au_b/res_data 0, au_sub/res_cout 0, owner 0, last_grant 1, count 0. Operation in flight is discarded, no result issued.

## Timing
- Handshake at edge T -> au_* valid after T; result captured at edge T+LATENCY; resN_valid high from T+LATENCY.
- Result consumed at edge R -> IDLE during cycle after R; next handshake earliest at edge R+1. Minimum issue interval with res_ready tied high: LATENCY+2 cycles.
- reqN_ready and resN_valid are functions of registered state plus reqN_valid (no path from res_ready to req_ready).
- res_valid never asserted for both requesters simultaneously; never in IDLE or ISSUE.

## Test plan
- Single add, LATENCY=1: req0 a=0x0000_0005, b=0x0000_0003, sub=0 -> req0_ready one cycle, res0_valid at handshake+1, res_data=0x0000_0008, res_cout=0; res1_valid stays 0.
- Subtract with borrow and wrap: req1 a=0x0000_0003, b=0x0000_0005, sub=1 -> res_data=0xFFFF_FFFE, res_cout=0; a=0xFFFF_FFFF, b=0x0000_0001, sub=0 -> res_data=0, res_cout=1.
- Tie fairness: both valid continuously, res_ready high, 4 ops -> grant order 0,1,0,1; each result tagged to correct res_valid; issue interval exactly LATENCY+2.
- Backpressure: res0_ready held 0 for 5 cycles after result -> res0_valid, res_data stable all 5 cycles; req1 pending sees req1_ready=0 until cycle after res0 consumed.
- LATENCY=4: au_a/au_b/au_sub stable 4 cycles, result captured at handshake+4; changing au_sum before last cycle does not affect captured value.
- Reset mid-ISSUE: assert clr asynchronously between edges -> all outputs 0 immediately, no res_valid after release; next request after clr drops, with both valid, is granted to requester 0.
